// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ requesters, the arbiter and the FIFO write port.
// Optional stall_cnt is present only when FIFO_WR_ARB_STATS_EN is defined.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 64
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          wr_en;
    logic [FIFO_WIDTH-1:0]         wr_data;
    logic [$clog2(NUM_REQ)-1:0]    owner_id;
    logic                          busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]                   stall_cnt;
`endif

    modport master (
        output req, req_data, req_last, fifo_full,
        input  gnt, wr_en, wr_data, owner_id, busy
`ifdef FIFO_WR_ARB_STATS_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  req, req_data, req_last, fifo_full,
        output gnt, wr_en, wr_data, owner_id, busy
`ifdef FIFO_WR_ARB_STATS_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-aware arbiter sharing one FIFO write port; FIFO_WR_ARB_STATS_EN adds stall_cnt.
// Latency: one IDLE arbitration cycle per burst, then zero-latency gnt/wr_en/wr_data from the owner.
// Backpressure: fifo_full freezes the burst (no gnt, no wr_en, beat count held) without losing ownership.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 64,
    parameter int MAX_BURST  = 4
) (
    input  logic             wrclk,
    input  logic             wrst_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  owner_id;
    logic [IDW-1:0]  win_idx;
    logic            win_vld;
    logic [CW-1:0]   beat_cnt;
    logic            own_req;
    logic            own_last;
    logic            accept;
    logic            release_burst;

    // Scan downward so the lowest offset from rr_ptr+1 is the last (winning) assignment.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (bus.req[(int'(rr_ptr) + i) % NUM_REQ]) begin
                win_vld = 1'b1;
                win_idx = IDW'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign own_req  = bus.req[owner_id];
    assign own_last = bus.req_last[owner_id];
    assign accept   = (state == BURST) && own_req && !bus.fifo_full;

    // A withdrawn req only counts when not full; under full the owner keeps its slot.
    assign release_burst = (state == BURST) &&
                           ((accept && (own_last || (beat_cnt == CW'(MAX_BURST - 1)))) ||
                            (!own_req && !bus.fifo_full));

    always_ff @(posedge wrclk or negedge wrst_n) begin
        if (!wrst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.gnt      = '0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = bus.req_data[int'(owner_id)*FIFO_WIDTH +: FIFO_WIDTH];
        bus.busy     = (state == BURST);
        bus.owner_id = owner_id;
        case (state)
            IDLE: begin
                if (win_vld) state_nxt = BURST;
            end
            BURST: begin
                if (accept) begin
                    bus.gnt[owner_id] = 1'b1;
                    bus.wr_en         = 1'b1;
                end
                if (release_burst) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wrclk or negedge wrst_n) begin
        if (!wrst_n) begin
            owner_id <= '0;
            rr_ptr   <= IDW'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else if (state == IDLE) begin
            if (win_vld) begin
                owner_id <= win_idx;
                beat_cnt <= '0;
            end
        end else begin
            if (accept)        beat_cnt <= beat_cnt + CW'(1);
            if (release_burst) rr_ptr   <= owner_id;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge wrclk or negedge wrst_n) begin
        if (!wrst_n)
            stall_cnt <= '0;
        else if ((state == BURST) && own_req && bus.fifo_full && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign bus.stall_cnt = stall_cnt;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector tables plus hand-written reset and MAX_BURST=1 sequences.
module tb_fifo_wr_arbiter;
    logic clk;
    logic rst_n;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .FIFO_WIDTH(64)) bus ();
    fifo_wr_arbiter_if #(.NUM_REQ(4), .FIFO_WIDTH(64)) bus2 ();

    fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(64), .MAX_BURST(4)) dut (
        .wrclk  (clk),
        .wrst_n (rst_n),
        .bus    (bus)
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(64), .MAX_BURST(1)) dut1 (
        .wrclk  (clk),
        .wrst_n (rst_n),
        .bus    (bus2)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  last;
        logic        full;
        logic [3:0]  gnt;
        logic        wr;
        logic [1:0]  own;
        logic        busy;
        logic [63:0] data;
    } vec_t;

    vec_t       vq[$];
    int         tests;
    int         fails;
    int         cnt[4];
    int         wr_total;
    logic [3:0] exp6_gnt[8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] rq, input logic [3:0] lst, input logic fl,
                                input logic [3:0] g, input logic w, input int own,
                                input logic b, input int dsrc, input int dbeat);
        vec_t v;
        v.req  = rq;
        v.last = lst;
        v.full = fl;
        v.gnt  = g;
        v.wr   = w;
        v.own  = 2'(own);
        v.busy = b;
        v.data = {32'(dsrc), 32'(dbeat)};
        vq.push_back(v);
    endfunction

    // Each requester presents {id, beats already accepted from it}.
    task automatic drive_data();
        for (int i = 0; i < 4; i++) bus.req_data[i*64 +: 64] = {32'(i), 32'(cnt[i])};
    endtask

    task automatic tick();
        logic [3:0] g;
        g = bus.gnt;
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (g[i]) cnt[i]++;
        #1;
    endtask

    task automatic reset_dut();
        rst_n          = 1'b0;
        bus.req        = '0;
        bus.req_last   = '0;
        bus.fifo_full  = 1'b0;
        bus.req_data   = '0;
        bus2.req       = '0;
        bus2.req_last  = '0;
        bus2.fifo_full = 1'b0;
        bus2.req_data  = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string tag);
        wr_total = 0;
        for (int n = 0; n < vq.size(); n++) begin
            bus.req       = vq[n].req;
            bus.req_last  = vq[n].last;
            bus.fifo_full = vq[n].full;
            drive_data();
            #2;
            chk($sformatf("%s[%0d].gnt", tag, n), 64'(bus.gnt), 64'(vq[n].gnt));
            chk($sformatf("%s[%0d].wr_en", tag, n), 64'(bus.wr_en), 64'(vq[n].wr));
            chk($sformatf("%s[%0d].owner", tag, n), 64'(bus.owner_id), 64'(vq[n].own));
            chk($sformatf("%s[%0d].busy", tag, n), 64'(bus.busy), 64'(vq[n].busy));
            if (vq[n].wr) chk($sformatf("%s[%0d].data", tag, n), bus.wr_data, vq[n].data);
            if (n < 20 && bus.wr_en) wr_total++;
            tick();
        end
        vq.delete();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp6_gnt = '{4'h0, 4'h1, 4'h0, 4'h4, 4'h0, 4'h1, 4'h0, 4'h4};

        // Reset values
        reset_dut();
        chk("rst.gnt", 64'(bus.gnt), 64'h0);
        chk("rst.wr_en", 64'(bus.wr_en), 64'h0);
        chk("rst.busy", 64'(bus.busy), 64'h0);
        chk("rst.owner", 64'(bus.owner_id), 64'h0);
        chk("rst.dut1_busy", 64'(bus2.busy), 64'h0);
`ifdef FIFO_WR_ARB_STATS_EN
        chk("rst.stall_cnt", 64'(bus.stall_cnt), 64'h0);
`endif

        // Single 3-beat packet from requester 0
        add(4'b0001, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);
        add(4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 1, 0, 0);
        add(4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 1, 0, 1);
        add(4'b0001, 4'b0001, 0, 4'b0001, 1, 0, 1, 0, 2);
        add(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);
        run_table("t1");

        // All four streaming long packets: bursts of 4 in order 0,1,2,3,0
        reset_dut();
        add(4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 4; k++)
                add(4'b1111, 4'b0000, 0, 4'(1 << (b % 4)), 1, b % 4, 1, b % 4, (b / 4) * 4 + k);
            if (b < 4) add(4'b1111, 4'b0000, 0, 4'b0000, 0, b, 0, 0, 0);
        end
        run_table("t2");
        chk("t2.writes_in_20", 64'(wr_total), 64'd16);

        // Requester 2 stalled by fifo_full for 5 cycles after its first beat
        reset_dut();
        add(4'b0100, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);
        add(4'b0100, 4'b0000, 0, 4'b0100, 1, 2, 1, 2, 0);
        for (int k = 0; k < 5; k++) add(4'b0100, 4'b0000, 1, 4'b0000, 0, 2, 1, 0, 0);
        add(4'b0100, 4'b0000, 0, 4'b0100, 1, 2, 1, 2, 1);
        add(4'b0100, 4'b0000, 0, 4'b0100, 1, 2, 1, 2, 2);
        add(4'b0100, 4'b0100, 0, 4'b0100, 1, 2, 1, 2, 3);
        add(4'b0000, 4'b0000, 0, 4'b0000, 0, 2, 0, 0, 0);
        run_table("t3");
`ifdef FIFO_WR_ARB_STATS_EN
        chk("t3.stall_cnt", 64'(bus.stall_cnt), 64'd5);
`endif

        // Owner 1 withdraws after 2 beats; 3 must beat 0 because rr_ptr moved to 1
        reset_dut();
        add(4'b1010, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);
        add(4'b1010, 4'b0000, 0, 4'b0010, 1, 1, 1, 1, 0);
        add(4'b1010, 4'b0000, 0, 4'b0010, 1, 1, 1, 1, 1);
        add(4'b1000, 4'b0000, 0, 4'b0000, 0, 1, 1, 0, 0);
        add(4'b1001, 4'b0000, 0, 4'b0000, 0, 1, 0, 0, 0);
        add(4'b1001, 4'b1000, 0, 4'b1000, 1, 3, 1, 3, 0);
        add(4'b0001, 4'b0000, 0, 4'b0000, 0, 3, 0, 0, 0);
        add(4'b0001, 4'b0001, 0, 4'b0001, 1, 0, 1, 0, 0);
        run_table("t4");

        // Asynchronous reset during beat 2 of a burst
        reset_dut();
        add(4'b0001, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);
        add(4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 1, 0, 0);
        run_table("t5");
        bus.req = 4'b0001;
        drive_data();
        #2;
        chk("t5.gnt_before_rst", 64'(bus.gnt), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("t5.gnt_in_rst", 64'(bus.gnt), 64'h0);
        chk("t5.wr_en_in_rst", 64'(bus.wr_en), 64'h0);
        chk("t5.busy_in_rst", 64'(bus.busy), 64'h0);
        bus.req = 4'b0011;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t5.owner_after", 64'(bus.owner_id), 64'h0);
        chk("t5.busy_after", 64'(bus.busy), 64'h1);
        chk("t5.gnt_after", 64'(bus.gnt), 64'h1);

        // MAX_BURST=1: single beats alternating 0,2,0,2 with an arbitration cycle between
        reset_dut();
        bus2.req = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            #2;
            chk($sformatf("t6[%0d].gnt", k), 64'(bus2.gnt), 64'(exp6_gnt[k]));
            chk($sformatf("t6[%0d].wr_en", k), 64'(bus2.wr_en), 64'(k % 2));
            chk($sformatf("t6[%0d].busy", k), 64'(bus2.busy), 64'(k % 2));
            if (k % 2 == 1) begin
                chk($sformatf("t6[%0d].owner", k), 64'(bus2.owner_id), (k % 4 == 1) ? 64'd0 : 64'd2);
                chk($sformatf("t6[%0d].data", k), bus2.wr_data, (k % 4 == 1) ? 64'hA0 : 64'hA2);
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
